i2c_ahb_master_ctrl: RTL and testbench

- AHB-Lite master sequencer between the I2C-to-AHB slave bridge and the system bus.
- Accepts single-cycle write and read request pulses with their address/data, and buffers one pending request per direction.
- Arbitrates round-robin between read and write, runs one non-pipelined SINGLE word transfer at a time, and returns read data in a stable holding register.
- Reports completion, bus error, wait-state timeout and request overflow.

---
 rtl/i2c_ahb_pkg.sv | 30 +++
 rtl/ahb_req_slot.sv | 56 +++++
 rtl/i2c_ahb_master_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_i2c_ahb_master_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ahb_pkg.sv
// i2c_ahb_pkg: shared AHB-Lite constants, sequencer state encoding and request-slot type
// Revision: 1.0
`default_nettype none

package i2c_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int TMO_W   = 8;
    localparam int SLOT_AW = 32;
    localparam int SLOT_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_DW-1:0] data;
    } req_slot_t;

endpackage

`default_nettype wire

// File: rtl/ahb_req_slot.sv
// ahb_req_slot: one-deep request buffer per direction with overwrite/overflow detection
// Revision: 1.0
`default_nettype none

module ahb_req_slot
    import i2c_ahb_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               req_i,
    input  logic [SLOT_AW-1:0] addr_i,
    input  logic [SLOT_DW-1:0] data_i,
    input  logic               grant_i,
    input  logic               done_i,
    output req_slot_t          slot_o,
    output logic               ovf_o
);

    req_slot_t slot_q, slot_d;
    logic      infl_q, infl_d;

    // The sequencer copies the request out at grant, so valid drops there;
    // a pulse arriving while in flight re-arms the slot for a follow-up transfer.
    always_comb begin
        slot_d = slot_q;
        infl_d = infl_q;
        if (grant_i) begin
            slot_d.valid = 1'b0;
            infl_d       = 1'b1;
        end
        if (done_i) begin
            infl_d = 1'b0;
        end
        if (req_i) begin
            slot_d.valid = 1'b1;
            slot_d.addr  = addr_i;
            slot_d.data  = data_i;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            slot_q <= '0;
            infl_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            infl_q <= infl_d;
        end
    end

    assign slot_o = slot_q;
    assign ovf_o  = req_i & (slot_q.valid | infl_q);

endmodule

`default_nettype wire

// File: rtl/i2c_ahb_master_ctrl.sv
// i2c_ahb_master_ctrl: round-robin AHB-Lite SINGLE-transfer sequencer for the I2C bridge
// Revision: 1.0
`default_nettype none

module i2c_ahb_master_ctrl
    import i2c_ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              wr_done_o,
    output logic              rd_done_o,
    output logic              err_o,
    output logic              ovf_o,
    input  logic              err_clr_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  haddr_q, haddr_d;
    logic               hwrite_q, hwrite_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               rd_next_q, rd_next_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               wr_done_q, wr_done_d;
    logic               rd_done_q, rd_done_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;

    req_slot_t wr_slot, rd_slot;
    logic      wr_grant, rd_grant, wr_fin, rd_fin, wr_ovf, rd_ovf;
    logic      pick_rd, err_set;
    logic      unused_rd_slot_data;

    ahb_req_slot u_wr_slot (
        .Clk     (Clk),
        .Rst     (Rst),
        .req_i   (wr_req_i),
        .addr_i  (SLOT_AW'(wr_addr_i)),
        .data_i  (SLOT_DW'(wr_data_i)),
        .grant_i (wr_grant),
        .done_i  (wr_fin),
        .slot_o  (wr_slot),
        .ovf_o   (wr_ovf)
    );

    ahb_req_slot u_rd_slot (
        .Clk     (Clk),
        .Rst     (Rst),
        .req_i   (rd_req_i),
        .addr_i  (SLOT_AW'(rd_addr_i)),
        .data_i  ('0),
        .grant_i (rd_grant),
        .done_i  (rd_fin),
        .slot_o  (rd_slot),
        .ovf_o   (rd_ovf)
    );

    assign unused_rd_slot_data = ^rd_slot.data;

    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rd_next_d = rd_next_q;
        rd_data_d = rd_data_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        wr_fin    = 1'b0;
        rd_fin    = 1'b0;
        err_set   = 1'b0;
        pick_rd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_slot.valid || rd_slot.valid) begin
                    // rd_next_q remembers the opposite of the last grant
                    pick_rd   = rd_slot.valid && (!wr_slot.valid || rd_next_q);
                    rd_grant  = pick_rd;
                    wr_grant  = !pick_rd;
                    rd_next_d = !pick_rd;
                    hwrite_d  = !pick_rd;
                    haddr_d   = pick_rd ? ADDR_W'(rd_slot.addr) : ADDR_W'(wr_slot.addr);
                    wdata_d   = DATA_W'(wr_slot.data);
                    cnt_d     = '0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d   = ST_IDLE;
                    wr_fin    = hwrite_q;
                    rd_fin    = !hwrite_q;
                    wr_done_d = hwrite_q;
                    rd_done_d = !hwrite_q;
                    if (HRESP) begin
                        err_set = 1'b1;
                    end else if (!hwrite_q) begin
                        rd_data_d = HRDATA;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO_LIM) begin
                        err_set = 1'b1;
                        wr_fin  = hwrite_q;
                        rd_fin  = !hwrite_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = err_set | (err_q & ~err_clr_i);
        ovf_d = wr_ovf | rd_ovf | (ovf_q & ~err_clr_i);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rd_next_q <= 1'b1;
            rd_data_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rd_next_q <= rd_next_d;
            rd_data_q <= rd_data_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HWDATA    = (state_q == ST_DATA && hwrite_q) ? wdata_q : '0;
    assign rd_data_o = rd_data_q;
    assign wr_done_o = wr_done_q;
    assign rd_done_o = rd_done_q;
    assign err_o     = err_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = (state_q != ST_IDLE) || wr_slot.valid || rd_slot.valid;

endmodule

`default_nettype wire

// File: tb/tb_i2c_ahb_master_ctrl.sv
// tb_i2c_ahb_master_ctrl: directed + randomized bench with a transaction-level reference model
// Revision: 1.0
`default_nettype none

module tb_i2c_ahb_master_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        wr_req_i, rd_req_i, err_clr_i;
    logic [31:0] wr_addr_i, wr_data_i, rd_addr_i;
    logic [31:0] rd_data_o;
    logic        wr_done_o, rd_done_o, err_o, ovf_o, busy_o;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    always #5 Clk = ~Clk;

    i2c_ahb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(255)) dut (
        .Clk(Clk), .Rst(Rst),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .wr_done_o(wr_done_o), .rd_done_o(rd_done_o), .err_o(err_o), .ovf_o(ovf_o),
        .err_clr_i(err_clr_i), .busy_o(busy_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending requests, in-flight flags, arbitration preference, sticky flags
    bit          m_wr_v, m_rd_v, m_infl_wr, m_infl_rd, m_rd_next, m_err, m_ovf;
    logic [31:0] m_wr_a, m_wr_d, m_rd_a, m_rdata;
    bit          cur_rd, cur_resp;
    logic [31:0] cur_wdata, cur_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_v = 0; m_rd_v = 0; m_infl_wr = 0; m_infl_rd = 0;
        m_rd_next = 1; m_err = 0; m_ovf = 0; m_rdata = '0;
    endtask

    task automatic pulse(input bit do_wr, input bit do_rd,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
        wr_req_i = do_wr; wr_addr_i = wa; wr_data_i = wd;
        rd_req_i = do_rd; rd_addr_i = ra;
        if (do_wr) begin
            if (m_wr_v || m_infl_wr) m_ovf = 1;
            m_wr_v = 1; m_wr_a = wa; m_wr_d = wd;
        end
        if (do_rd) begin
            if (m_rd_v || m_infl_rd) m_ovf = 1;
            m_rd_v = 1; m_rd_a = ra;
        end
        @(negedge Clk);
        wr_req_i = 0; rd_req_i = 0;
    endtask

    task automatic clr_err();
        err_clr_i = 1;
        @(negedge Clk);
        err_clr_i = 0;
        m_err = 0; m_ovf = 0;
        chk("err_cleared", err_o, 1'b0);
        chk("ovf_cleared", ovf_o, 1'b0);
    endtask

    task automatic serve_addr(input int n_low, input bit resp, input logic [31:0] rdata,
                              output int waited);
        bit found = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (HTRANS == 2'b10) begin
                found = 1;
                break;
            end
            @(negedge Clk);
            waited++;
        end
        chk("nonseq_seen", found, 1'b1);
        cur_rd = m_rd_v && (!m_wr_v || m_rd_next);
        m_rd_next = !cur_rd;
        if (cur_rd) begin
            chk("haddr_rd", HADDR, m_rd_a);
            m_rd_v = 0; m_infl_rd = 1;
        end else begin
            chk("haddr_wr", HADDR, m_wr_a);
            cur_wdata = m_wr_d;
            m_wr_v = 0; m_infl_wr = 1;
        end
        chk("hwrite", HWRITE, !cur_rd);
        @(negedge Clk);
        chk("htrans_data_phase", HTRANS, 2'b00);
        chk("hwdata", HWDATA, cur_rd ? 32'h0 : cur_wdata);
        HREADY = (n_low == 0); HRESP = resp; HRDATA = rdata;
        cur_resp = resp; cur_rdata = rdata;
    endtask

    task automatic serve_data(input int n_low);
        repeat (n_low) @(negedge Clk);
        HREADY = 1;
        @(negedge Clk);
        if (cur_resp) m_err = 1;
        else if (cur_rd) m_rdata = cur_rdata;
        if (cur_rd) m_infl_rd = 0; else m_infl_wr = 0;
        chk("wr_done", wr_done_o, !cur_rd);
        chk("rd_done", rd_done_o, cur_rd);
        chk("rd_data", rd_data_o, m_rdata);
        chk("err", err_o, m_err);
        chk("ovf", ovf_o, m_ovf);
        chk("htrans_gap", HTRANS, 2'b00);
        HRESP = 0;
        @(negedge Clk);
        chk("done_one_cycle", {wr_done_o, rd_done_o}, 2'b00);
    endtask

    task automatic xfer(input int n_low, input bit resp, input logic [31:0] rdata);
        int w;
        serve_addr(n_low, resp, rdata, w);
        serve_data(n_low);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, mode;
        logic [31:0] wa, wd, ra;
        Rst = 1; wr_req_i = 0; rd_req_i = 0; err_clr_i = 0;
        wr_addr_i = 0; wr_data_i = 0; rd_addr_i = 0;
        HREADY = 1; HRESP = 0; HRDATA = 0;
        model_reset();
        repeat (2) @(negedge Clk);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_outs", {wr_done_o, rd_done_o, err_o, ovf_o, HWRITE}, 5'b0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_rdata", rd_data_o, 32'h0);
        chk("hsize", HSIZE, 3'b010);
        chk("hburst", HBURST, 3'b000);
        Rst = 0;
        @(negedge Clk);

        // zero-wait write and latency
        pulse(1, 0, 32'h2000_0010, 32'hDEAD_BEEF, 0);
        chk("lat_idle_after_capture", HTRANS, 2'b00);
        chk("lat_busy", busy_o, 1'b1);
        serve_addr(0, 0, 0, w);
        chk("lat_nonseq_cycle", w, 1);
        serve_data(0);

        // read with 3 wait states, then a write that must not disturb rd_data_o
        pulse(0, 1, 0, 0, 32'h4000_0004);
        xfer(3, 0, 32'h1234_5678);
        pulse(1, 0, 32'h2000_0020, 32'hCAFE_0001, 0);
        xfer(1, 0, 32'hFFFF_FFFF);

        // reset in the middle of a data phase
        pulse(1, 0, 32'h2000_0030, 32'h5555_AAAA, 0);
        serve_addr(5, 0, 0, w);
        #2 Rst = 1;
        #1;
        chk("midrst_htrans", HTRANS, 2'b00);
        chk("midrst_bus", {HADDR, HWDATA}, 64'h0);
        chk("midrst_outs", {HWRITE, busy_o, wr_done_o, rd_done_o, err_o, ovf_o}, 6'b0);
        chk("midrst_rdata", rd_data_o, 32'h0);
        @(negedge Clk);
        Rst = 0; HREADY = 1;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("postrst_busy", busy_o, 1'b0);

        // simultaneous pulses right after reset: read first
        pulse(1, 1, 32'h2000_0040, 32'h0BAD_F00D, 32'h4000_0040);
        xfer(0, 0, 32'hA5A5_0001);
        xfer(2, 0, 32'h0);

        // overflow while the write is in flight; latest request wins
        pulse(1, 0, 32'h2000_0050, 32'h1111_1111, 0);
        serve_addr(3, 0, 0, w);
        pulse(1, 0, 32'h2000_0054, 32'h2222_2222, 0);
        serve_data(2);
        xfer(0, 0, 32'h0);
        clr_err();

        // data-phase timeout
        pulse(1, 0, 32'h2000_0060, 32'h3333_3333, 0);
        serve_addr(255, 0, 0, w);
        repeat (254) @(negedge Clk);
        chk("tmo_still_busy", busy_o, 1'b1);
        @(negedge Clk);
        m_err = 1; m_infl_wr = 0;
        chk("tmo_busy", busy_o, 1'b0);
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_htrans", HTRANS, 2'b00);
        chk("tmo_no_done", wr_done_o, 1'b0);
        HREADY = 1;
        @(negedge Clk);
        chk("tmo_no_late_done", wr_done_o, 1'b0);
        clr_err();

        // error response on a read
        pulse(0, 1, 0, 0, 32'h4000_0070);
        xfer(1, 1, 32'h7777_7777);
        clr_err();

        // randomized traffic
        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 2);
            wa = $urandom; wd = $urandom; ra = $urandom;
            pulse(mode != 1, mode != 0, wa, wd, ra);
            repeat ((mode == 2) ? 2 : 1)
                xfer($urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) clr_err();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
